// File: rtl/core_pkg.sv
// Shared core types: data width, write-mask width and arbiter port IDs.
// Used by mem_arbiter and its owner FIFO.
package core_pkg;

  localparam int Xlen     = 32;
  localparam int MaskBits = Xlen / 8;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_port_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which port issued each outstanding request.
// Pointers wrap explicitly so any depth >= 1 works.
module arb_owner_fifo
  import core_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  arb_port_e push_id_i,
  output arb_port_e head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  arb_port_e         mem_q [Depth];
  arb_port_e         mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= INST;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one INST/DATA memory port arbiter with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin; default is fixed DATA priority.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic [Xlen-1:0]     inst_addr_i,
  input  logic [Xlen-1:0]     inst_wdata_i,
  input  logic [MaskBits-1:0] inst_wmask_i,
  output logic [Xlen-1:0]     inst_rdata_o,
  output logic                inst_rvalid_o,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [Xlen-1:0]     data_addr_i,
  input  logic [Xlen-1:0]     data_wdata_i,
  input  logic [MaskBits-1:0] data_wmask_i,
  output logic [Xlen-1:0]     data_rdata_o,
  output logic                data_rvalid_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i
);

  arb_port_e win;
  arb_port_e lock_id_q, lock_id_d;
  arb_port_e head;
  logic      lock_q, lock_d;
  logic      win_valid;
  logic      gnt_ok;
  logic      accept;
  logic      pop;
  logic      fifo_full, fifo_empty;

`ifdef MEM_ARB_RR_EN
  arb_port_e last_q, last_d;
`endif

  always_comb begin
    win = INST;
    if (lock_q) begin
      win = lock_id_q;
    end else if (inst_valid_i && data_valid_i) begin
`ifdef MEM_ARB_RR_EN
      win = (last_q == DATA) ? INST : DATA;
`else
      win = DATA;
`endif
    end else if (data_valid_i) begin
      win = DATA;
    end
  end

  assign win_valid = (win == DATA) ? data_valid_i : inst_valid_i;
  assign gnt_ok    = !rst_i && !fifo_full;

  assign mem_valid_o  = win_valid && gnt_ok;
  assign mem_addr_o   = (win == DATA) ? data_addr_i  : inst_addr_i;
  assign mem_wdata_o  = (win == DATA) ? data_wdata_i : inst_wdata_i;
  assign mem_wmask_o  = (win == DATA) ? data_wmask_i : inst_wmask_i;
  assign inst_ready_o = gnt_ok && mem_ready_i && (win == INST);
  assign data_ready_o = gnt_ok && mem_ready_i && (win == DATA);

  assign accept = mem_valid_o && mem_ready_i;
  assign pop    = mem_rvalid_i && !fifo_empty && !rst_i;

  assign inst_rvalid_o = pop && (head == INST);
  assign data_rvalid_o = pop && (head == DATA);
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;

  // A stalled request keeps its source until memory takes it.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_valid_o && !mem_ready_i) begin
      lock_d    = 1'b1;
      lock_id_d = win;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= INST;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= INST;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_rvalid_i) begin
      assert (!fifo_empty)
        else $warning("mem_arbiter: rvalid with no outstanding request dropped");
    end
  end

  arb_owner_fifo #(
    .Depth(MaxOutstanding)
  ) u_owner_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (accept),
    .pop_i    (pop),
    .push_id_i(win),
    .head_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a two-entry owner FIFO.
// Expected owners/data are queued at acceptance and checked on rvalid.
module tb_mem_arbiter;
  import core_pkg::*;

  localparam int Depth = 2;

`ifdef MEM_ARB_RR_EN
  localparam arb_port_e Second = INST;
  localparam arb_port_e Third  = DATA;
`else
  localparam arb_port_e Second = DATA;
  localparam arb_port_e Third  = INST;
`endif

  typedef struct packed {
    arb_port_e       port;
    logic [Xlen-1:0] data;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                inst_valid_i, inst_ready_o;
  logic [Xlen-1:0]     inst_addr_i, inst_wdata_i, inst_rdata_o;
  logic [MaskBits-1:0] inst_wmask_i;
  logic                inst_rvalid_o;
  logic                data_valid_i, data_ready_o;
  logic [Xlen-1:0]     data_addr_i, data_wdata_i, data_rdata_o;
  logic [MaskBits-1:0] data_wmask_i;
  logic                data_rvalid_o;
  logic                mem_valid_o, mem_ready_i;
  logic [Xlen-1:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [MaskBits-1:0] mem_wmask_o;
  logic                mem_rvalid_i;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .MaxOutstanding(Depth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .inst_addr_i  (inst_addr_i),
    .inst_wdata_i (inst_wdata_i),
    .inst_wmask_i (inst_wmask_i),
    .inst_rdata_o (inst_rdata_o),
    .inst_rvalid_o(inst_rvalid_o),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_wmask_i (data_wmask_i),
    .data_rdata_o (data_rdata_o),
    .data_rvalid_o(data_rvalid_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [Xlen-1:0] dat(input logic [Xlen-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle();
    inst_valid_i = 1'b0;
    inst_addr_i  = '0;
    inst_wdata_i = '0;
    inst_wmask_i = '0;
    data_valid_i = 1'b0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    data_wmask_i = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic acc_chk(input string tag, input arb_port_e p,
                         input logic [Xlen-1:0] a,
                         input logic [Xlen-1:0] d);
    exp_t e;
    chk({tag, "_mvalid"}, 32'(mem_valid_o), 1);
    chk({tag, "_maddr"}, mem_addr_o, a);
    chk({tag, "_irdy"}, 32'(inst_ready_o), 32'(p == INST));
    chk({tag, "_drdy"}, 32'(data_ready_o), 32'(p == DATA));
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic blk_chk(input string tag);
    chk({tag, "_mvalid"}, 32'(mem_valid_o), 0);
    chk({tag, "_irdy"}, 32'(inst_ready_o), 0);
    chk({tag, "_drdy"}, 32'(data_ready_o), 0);
  endtask

  task automatic rsp_set();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = (exp_q.size() > 0) ? exp_q[0].data : 32'hDEAD_BEEF;
  endtask

  task automatic rsp_chk(input string tag);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_irv"}, 32'(inst_rvalid_o), 32'(e.port == INST));
      chk({tag, "_drv"}, 32'(data_rvalid_o), 32'(e.port == DATA));
      chk({tag, "_irdata"}, inst_rdata_o, e.data);
      chk({tag, "_drdata"}, data_rdata_o, e.data);
    end else begin
      chk({tag, "_irv_drop"}, 32'(inst_rvalid_o), 0);
      chk({tag, "_drv_drop"}, 32'(data_rvalid_o), 0);
    end
  endtask

  task automatic ret(input string tag);
    rsp_set();
    mid();
    rsp_chk(tag);
    step();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i        = 1'b1;
    mem_ready_i  = 1'b1;
    inst_valid_i = 1'b1;
    data_valid_i = 1'b1;
    mem_rvalid_i = 1'b1;
    step();
    mid();
    blk_chk("rst");
    chk("rst_irv", 32'(inst_rvalid_o), 0);
    chk("rst_drv", 32'(data_rvalid_o), 0);
    step();
    rst_i = 1'b0;
    idle();
    step();

    // single read
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h0;
    mid();
    acc_chk("rd", INST, 32'h0, 32'h0000_0013);
    chk("rd_wmask", 32'(mem_wmask_o), 0);
    step();
    inst_valid_i = 1'b0;
    mid();
    chk("rd_idle", 32'(mem_valid_o), 0);
    step();
    ret("rd_rsp");

    // contention, then full
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h100;
    data_valid_i = 1'b1;
    data_addr_i  = 32'h200;
    data_wdata_i = 32'hCAFE_F00D;
    data_wmask_i = 4'hF;
    mid();
    acc_chk("tie1", DATA, 32'h200, dat(32'h200));
    chk("tie1_wmask", 32'(mem_wmask_o), 32'hF);
    chk("tie1_wdata", mem_wdata_o, 32'hCAFE_F00D);
    step();
    data_addr_i = 32'h204;
    mid();
    acc_chk("tie2", Second, (Second == INST) ? 32'h100 : 32'h204,
            dat((Second == INST) ? 32'h100 : 32'h204));
    step();
    if (Second == INST) inst_valid_i = 1'b0;
    else data_valid_i = 1'b0;
    mid();
    blk_chk("full");
    step();
    rsp_set();
    mid();
    rsp_chk("full_pop1");
    blk_chk("popblk");
    step();
    mem_rvalid_i = 1'b0;
    mid();
    acc_chk("after_pop", Third, (Third == INST) ? 32'h100 : 32'h204,
            dat((Third == INST) ? 32'h100 : 32'h204));
    step();
    idle();
    ret("full_pop2");
    ret("full_pop3");

    // lock: INST stalled, DATA arrives late
    mem_ready_i  = 1'b0;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h300;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        data_valid_i = 1'b1;
        data_addr_i  = 32'h400;
      end
      mid();
      chk("lock_mvalid", 32'(mem_valid_o), 1);
      chk("lock_maddr", mem_addr_o, 32'h300);
      chk("lock_irdy", 32'(inst_ready_o), 0);
      step();
    end
    mem_ready_i = 1'b1;
    mid();
    acc_chk("lock_rel", INST, 32'h300, dat(32'h300));
    step();
    inst_valid_i = 1'b0;
    mid();
    acc_chk("lock_next", DATA, 32'h400, dat(32'h400));
    step();
    idle();
    ret("lock_rsp1");
    ret("lock_rsp2");

    // concurrent push/pop at occupancy 1
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h500;
    mid();
    acc_chk("pp_a", INST, 32'h500, dat(32'h500));
    step();
    inst_valid_i = 1'b0;
    data_valid_i = 1'b1;
    data_addr_i  = 32'h600;
    rsp_set();
    mid();
    acc_chk("pp_b", DATA, 32'h600, dat(32'h600));
    rsp_chk("pp_pop");
    step();
    mem_rvalid_i = 1'b0;
    data_valid_i = 1'b0;
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h700;
    mid();
    acc_chk("pp_c", INST, 32'h700, dat(32'h700));
    step();
    idle();
    ret("pp_rsp1");
    ret("pp_rsp2");

    // reset with two requests in flight
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'h800;
    mid();
    acc_chk("rf_a", INST, 32'h800, dat(32'h800));
    step();
    inst_valid_i = 1'b0;
    data_valid_i = 1'b1;
    data_addr_i  = 32'h900;
    mid();
    acc_chk("rf_b", DATA, 32'h900, dat(32'h900));
    step();
    rst_i = 1'b1;
    inst_valid_i = 1'b1;
    mid();
    blk_chk("rf_rst");
    exp_q.delete();
    step();
    rst_i = 1'b0;
    idle();
    ret("rf_drop1");
    ret("rf_drop2");
    inst_valid_i = 1'b1;
    inst_addr_i  = 32'hA00;
    mid();
    acc_chk("rf_new", INST, 32'hA00, dat(32'hA00));
    step();
    idle();
    step();
    ret("rf_new_rsp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
